// File: rtl/piso_pkg.sv
// Shared definitions for the serial shift-register link: transmitter state
// encoding and the default word width used by both ends of the link.
package piso_pkg;

  localparam int unsigned PISO_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage : piso_pkg

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes an N-bit word over valid/ready
// and drives it LSB first on sout, one bit per clock with EN high.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned N = PISO_WIDTH
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] din,
  input  logic         EN,
  output logic         sout,
  output logic         sout_valid,
  output logic         done
);

  localparam int unsigned      CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_shreg;
  logic [N-1:0]     w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_last;
  logic             w_accept;

  // Last bit is being consumed this cycle; a new word may be taken in its place.
  always_comb begin
    w_last     = (r_state == ST_SHIFT) && EN && (r_cnt == CNT_LAST);
    load_ready = !RST && ((r_state == ST_IDLE) || w_last);
    w_accept   = load_valid && load_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (EN) begin
          w_shreg_nxt = r_shreg >> 1;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A load overrides the shift and keeps the line busy without a gap.
    if (w_accept) begin
      w_shreg_nxt = din;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_SHIFT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sout       <= (w_state_nxt == ST_SHIFT) ? w_shreg_nxt[0] : 1'b0;
      r_sout_valid <= (w_state_nxt == ST_SHIFT);
      r_done       <= w_done_nxt;
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign done       = r_done;

endmodule : piso_serializer
